// File: rtl/branch_rs.sv
// Branch reservation station: buffers dispatched branch ops until both
// operands are available from the CDBs, then issues the lowest-index ready
// op per cycle into the Branch unit through registered outputs.
//
// Dispatch handshake: dispEn is a request and !rsFull is the grant. A
// dispatch completes at a rising edge only when dispEn=1, rsFull=0 and
// flush=0. While rsFull=1 the dispatcher holds its request unchanged.
module branch_rs #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              dispEn,
    input  logic [OP_W-1:0]   dispOp,
    input  logic              dispValO,
    input  logic [DATA_W-1:0] dispDataO,
    input  logic [TAG_W-1:0]  dispTagO,
    input  logic              dispValT,
    input  logic [DATA_W-1:0] dispDataT,
    input  logic [TAG_W-1:0]  dispTagT,
    input  logic [DATA_W-1:0] dispImm,
    input  logic [DATA_W-1:0] dispPC,
    input  logic [1:0]        dispBNum,
    input  logic              cdbAEn,
    input  logic [TAG_W-1:0]  cdbATag,
    input  logic [DATA_W-1:0] cdbAData,
    input  logic              cdbBEn,
    input  logic [TAG_W-1:0]  cdbBTag,
    input  logic [DATA_W-1:0] cdbBData,
    output logic              rsFull,
    output logic              BranchWorkEn,
    output logic [DATA_W-1:0] operandO,
    output logic [DATA_W-1:0] operandT,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] PC,
    output logic [OP_W-1:0]   opCode,
    output logic [1:0]        bNum
);

    localparam int IDX_W = $clog2(DEPTH);

    // Entry storage
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_valO;
    logic [DEPTH-1:0]  r_valT;
    logic [DATA_W-1:0] r_dataO [DEPTH];
    logic [DATA_W-1:0] r_dataT [DEPTH];
    logic [TAG_W-1:0]  r_tagO  [DEPTH];
    logic [TAG_W-1:0]  r_tagT  [DEPTH];
    logic [OP_W-1:0]   r_op    [DEPTH];
    logic [DATA_W-1:0] r_imm   [DEPTH];
    logic [DATA_W-1:0] r_pc    [DEPTH];
    logic [1:0]        r_bnum  [DEPTH];

    logic [DEPTH-1:0]  w_ready;
    logic [IDX_W-1:0]  w_free_idx;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_any_ready;
    logic              w_full;
    logic              w_disp_fire;

    // Operand capture: an already-valid operand is kept; a waiting one takes
    // the data of a matching CDB, cdbA taking precedence over cdbB.
    // Returns {valid, data}.
    function automatic logic [DATA_W:0] capture(input logic val,
                                                input logic [DATA_W-1:0] data,
                                                input logic [TAG_W-1:0] tag);
        if (val)
            return {1'b1, data};
        else if (cdbAEn && (cdbATag == tag))
            return {1'b1, cdbAData};
        else if (cdbBEn && (cdbBTag == tag))
            return {1'b1, cdbBData};
        else
            return {1'b0, data};
    endfunction

    assign w_full      = &r_valid;
    assign rsFull      = w_full;
    assign w_disp_fire = dispEn & ~w_full;
    assign w_any_ready = |w_ready;

    // Ready vector and lowest-index free / ready entry selection
    always_comb begin
        w_ready    = '0;
        w_free_idx = '0;
        w_sel_idx  = '0;
        for (int i = 0; i < DEPTH; i++)
            w_ready[i] = r_valid[i] & r_valO[i] & r_valT[i];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
            if (w_ready[i])  w_sel_idx  = IDX_W'(i);
        end
    end

    // Entry state: flush clears, otherwise wakeup, dispatch and issue
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_valO  <= '0;
            r_valT  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dataO[i] <= '0;
                r_dataT[i] <= '0;
                r_tagO[i]  <= '0;
                r_tagT[i]  <= '0;
                r_op[i]    <= '0;
                r_imm[i]   <= '0;
                r_pc[i]    <= '0;
                r_bnum[i]  <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            // Wakeup of resident entries; a ready entry is unaffected.
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i]) begin
                    {r_valO[i], r_dataO[i]} <= capture(r_valO[i], r_dataO[i], r_tagO[i]);
                    {r_valT[i], r_dataT[i]} <= capture(r_valT[i], r_dataT[i], r_tagT[i]);
                end
            end
            // Issue frees the selected entry (it is never the free slot).
            if (w_any_ready)
                r_valid[w_sel_idx] <= 1'b0;
            // Dispatch into the lowest free slot, with same-cycle CDB bypass.
            if (w_disp_fire) begin
                r_valid[w_free_idx] <= 1'b1;
                {r_valO[w_free_idx], r_dataO[w_free_idx]} <= capture(dispValO, dispDataO, dispTagO);
                {r_valT[w_free_idx], r_dataT[w_free_idx]} <= capture(dispValT, dispDataT, dispTagT);
                r_tagO[w_free_idx] <= dispTagO;
                r_tagT[w_free_idx] <= dispTagT;
                r_op[w_free_idx]   <= dispOp;
                r_imm[w_free_idx]  <= dispImm;
                r_pc[w_free_idx]   <= dispPC;
                r_bnum[w_free_idx] <= dispBNum;
            end
        end
    end

    // Issue bundle registers; data holds when nothing issues
    always_ff @(posedge clk) begin
        if (!rst) begin
            BranchWorkEn <= 1'b0;
            operandO     <= '0;
            operandT     <= '0;
            imm          <= '0;
            PC           <= '0;
            opCode       <= '0;
            bNum         <= '0;
        end else if (flush) begin
            BranchWorkEn <= 1'b0;
        end else begin
            BranchWorkEn <= w_any_ready;
            if (w_any_ready) begin
                operandO <= r_dataO[w_sel_idx];
                operandT <= r_dataT[w_sel_idx];
                imm      <= r_imm[w_sel_idx];
                PC       <= r_pc[w_sel_idx];
                opCode   <= r_op[w_sel_idx];
                bNum     <= r_bnum[w_sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Testbench for branch_rs: a cycle-by-cycle vector table covering reset,
// ready dispatch, wakeup, bypass, full and flush, then a hand-written
// sequence for simultaneous wakeup ordering.
module tb_branch_rs;

    localparam logic [5:0] OP_BEQ = 6'h01;
    localparam logic [5:0] OP_BNE = 6'h02;
    localparam logic [5:0] OP_BLT = 6'h03;
    localparam logic [5:0] OP_BGE = 6'h04;

    logic        clk = 1'b0;
    logic        rst, flush, dispEn;
    logic [5:0]  dispOp;
    logic        dispValO, dispValT;
    logic [31:0] dispDataO, dispDataT, dispImm, dispPC;
    logic [3:0]  dispTagO, dispTagT;
    logic [1:0]  dispBNum;
    logic        cdbAEn, cdbBEn;
    logic [3:0]  cdbATag, cdbBTag;
    logic [31:0] cdbAData, cdbBData;
    logic        rsFull, BranchWorkEn;
    logic [31:0] operandO, operandT, imm, PC;
    logic [5:0]  opCode;
    logic [1:0]  bNum;

    int n_tests = 0;
    int n_fail  = 0;

    branch_rs dut (
        .clk(clk), .rst(rst), .flush(flush), .dispEn(dispEn), .dispOp(dispOp),
        .dispValO(dispValO), .dispDataO(dispDataO), .dispTagO(dispTagO),
        .dispValT(dispValT), .dispDataT(dispDataT), .dispTagT(dispTagT),
        .dispImm(dispImm), .dispPC(dispPC), .dispBNum(dispBNum),
        .cdbAEn(cdbAEn), .cdbATag(cdbATag), .cdbAData(cdbAData),
        .cdbBEn(cdbBEn), .cdbBTag(cdbBTag), .cdbBData(cdbBData),
        .rsFull(rsFull), .BranchWorkEn(BranchWorkEn),
        .operandO(operandO), .operandT(operandT), .imm(imm), .PC(PC),
        .opCode(opCode), .bNum(bNum)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst, flush, den;
        logic [5:0]  op;
        logic        vo;  logic [31:0] d_o; logic [3:0] to;
        logic        vt;  logic [31:0] d_t; logic [3:0] tt;
        logic [31:0] imm, pc;
        logic [1:0]  bn;
        logic        ae;  logic [3:0] at; logic [31:0] ad;
        logic        be;  logic [3:0] bt; logic [31:0] bd;
        logic        x_full, x_work, x_chk;
        logic [5:0]  x_op;
        logic [31:0] x_o, x_t, x_imm, x_pc;
        logic [1:0]  x_bn;
    } vec_t;

    vec_t vecs[$];
    vec_t cv;

    // Vector construction helpers: start an idle vector, then modify it
    task automatic new_v(input string nm);
        cv = '{name: nm, rst: 1'b1, default: '0};
    endtask

    task automatic set_disp(input logic [5:0] op, input logic vo, input logic [31:0] d_o,
                            input logic [3:0] to, input logic vt, input logic [31:0] d_t,
                            input logic [3:0] tt, input logic [31:0] im, input logic [31:0] pc,
                            input logic [1:0] bn);
        cv.den = 1'b1; cv.op = op;
        cv.vo = vo; cv.d_o = d_o; cv.to = to;
        cv.vt = vt; cv.d_t = d_t; cv.tt = tt;
        cv.imm = im; cv.pc = pc; cv.bn = bn;
    endtask

    task automatic set_cdba(input logic [3:0] t, input logic [31:0] d);
        cv.ae = 1'b1; cv.at = t; cv.ad = d;
    endtask

    task automatic set_cdbb(input logic [3:0] t, input logic [31:0] d);
        cv.be = 1'b1; cv.bt = t; cv.bd = d;
    endtask

    task automatic expect_ctl(input logic f, input logic w);
        cv.x_full = f; cv.x_work = w;
    endtask

    task automatic expect_data(input logic [5:0] op, input logic [31:0] o, input logic [31:0] t,
                               input logic [31:0] im, input logic [31:0] pc, input logic [1:0] bn);
        cv.x_chk = 1'b1; cv.x_op = op; cv.x_o = o; cv.x_t = t;
        cv.x_imm = im; cv.x_pc = pc; cv.x_bn = bn;
    endtask

    task automatic push_v();
        vecs.push_back(cv);
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; flush = v.flush; dispEn = v.den; dispOp = v.op;
        dispValO = v.vo; dispDataO = v.d_o; dispTagO = v.to;
        dispValT = v.vt; dispDataT = v.d_t; dispTagT = v.tt;
        dispImm = v.imm; dispPC = v.pc; dispBNum = v.bn;
        cdbAEn = v.ae; cdbATag = v.at; cdbAData = v.ad;
        cdbBEn = v.be; cdbBTag = v.bt; cdbBData = v.bd;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_data(input string nm, input logic [5:0] op, input logic [31:0] o,
                              input logic [31:0] t, input logic [31:0] im,
                              input logic [31:0] pc, input logic [1:0] bn);
        check({nm, ".opCode"},   32'(opCode), 32'(op));
        check({nm, ".operandO"}, operandO, o);
        check({nm, ".operandT"}, operandT, t);
        check({nm, ".imm"},      imm, im);
        check({nm, ".PC"},       PC, pc);
        check({nm, ".bNum"},     32'(bNum), 32'(bn));
    endtask

    // Drive one cycle's inputs, clock, and sample #1 after the edge
    task automatic step_idle();
        new_v("idle");
        apply(cv);
        @(posedge clk); #1;
    endtask

    initial begin
        // ---- Reset
        new_v("reset0"); cv.rst = 1'b0; expect_data(6'h0, 0, 0, 0, 0, 0); push_v();
        new_v("reset1"); cv.rst = 1'b0; expect_data(6'h0, 0, 0, 0, 0, 0); push_v();
        // ---- Ready dispatch issues the cycle after
        new_v("rdy_disp"); set_disp(OP_BEQ, 1, 5, 0, 1, 5, 0, 8, 32'h100, 1); push_v();
        new_v("rdy_issue"); expect_ctl(0, 1); expect_data(OP_BEQ, 5, 5, 8, 32'h100, 1); push_v();
        new_v("rdy_after"); expect_data(OP_BEQ, 5, 5, 8, 32'h100, 1); push_v();
        // ---- Wakeup from cdbA two cycles after dispatch
        new_v("wk_disp"); set_disp(OP_BNE, 0, 0, 3, 1, 9, 0, 32'h20, 32'h200, 2); push_v();
        new_v("wk_wait"); push_v();
        new_v("wk_cdb"); set_cdba(3, 7); push_v();
        new_v("wk_issue"); expect_ctl(0, 1); expect_data(OP_BNE, 7, 9, 32'h20, 32'h200, 2); push_v();
        new_v("wk_after"); push_v();
        // ---- Dispatch bypass from cdbB
        new_v("byp_disp"); set_disp(OP_BGE, 0, 0, 2, 1, 1, 0, 4, 32'h300, 3);
        set_cdbb(2, 32'h55); push_v();
        new_v("byp_issue"); expect_ctl(0, 1); expect_data(OP_BGE, 32'h55, 1, 4, 32'h300, 3); push_v();
        // ---- Fill all four entries with waiting ops
        for (int i = 0; i < 4; i++) begin
            new_v($sformatf("full_disp%0d", i));
            set_disp(OP_BLT, 0, 0, 4'(4 + i), 1, 32'(i), 0, 32'(i), 32'h400 + 32'(4 * i), 2'(i));
            expect_ctl(i == 3, 0); push_v();
        end
        new_v("full_5th"); set_disp(OP_BGE, 1, 1, 0, 1, 1, 0, 0, 32'h500, 3);
        expect_ctl(1, 0); push_v();
        new_v("full_wake2"); set_cdba(6, 32'h66); expect_ctl(1, 0); push_v();
        new_v("full_issue2"); expect_ctl(0, 1); expect_data(OP_BLT, 32'h66, 2, 2, 32'h408, 2); push_v();
        new_v("full_quiet"); push_v();
        // ---- Flush with one ready entry and a competing dispatch
        new_v("fl_wake0"); set_cdbb(4, 32'h44); expect_ctl(0, 0); push_v();
        new_v("fl_flush"); cv.flush = 1'b1; set_disp(OP_BEQ, 1, 1, 0, 1, 1, 0, 0, 32'h600, 0);
        set_cdba(5, 32'h5); push_v();
        new_v("fl_cdb"); set_cdba(7, 1); set_cdbb(5, 2); push_v();
        new_v("fl_quiet"); expect_data(OP_BLT, 32'h66, 2, 2, 32'h408, 2); push_v();
        // ---- Both CDBs match a dispatched op: cdbA wins
        new_v("ab_disp"); set_disp(OP_BNE, 0, 0, 9, 0, 0, 9, 32'h10, 32'h700, 1);
        set_cdba(9, 32'hA); set_cdbb(9, 32'hB); push_v();
        new_v("ab_issue"); expect_ctl(0, 1); expect_data(OP_BNE, 32'hA, 32'hA, 32'h10, 32'h700, 1); push_v();

        // Run the table
        foreach (vecs[k]) begin
            apply(vecs[k]);
            @(posedge clk); #1;
            check({vecs[k].name, ".rsFull"}, 32'(rsFull), 32'(vecs[k].x_full));
            check({vecs[k].name, ".BranchWorkEn"}, 32'(BranchWorkEn), 32'(vecs[k].x_work));
            if (vecs[k].x_chk)
                check_data(vecs[k].name, vecs[k].x_op, vecs[k].x_o, vecs[k].x_t,
                           vecs[k].x_imm, vecs[k].x_pc, vecs[k].x_bn);
        end

        // ---- Two entries woken at once issue in index order on consecutive cycles
        new_v("ord0"); set_disp(OP_BEQ, 0, 0, 1, 1, 0, 0, 32'h1, 32'h800, 0);
        apply(cv); @(posedge clk); #1;
        new_v("ord1"); set_disp(OP_BNE, 0, 0, 2, 1, 0, 0, 32'h2, 32'h804, 1);
        apply(cv); @(posedge clk); #1;
        new_v("ord_cdb"); set_cdba(1, 32'h11); set_cdbb(2, 32'h22);
        apply(cv); @(posedge clk); #1;
        check("ord_cdb.BranchWorkEn", 32'(BranchWorkEn), 0);
        begin : wait_first
            int budget = 5;
            step_idle();
            while (!BranchWorkEn && budget > 0) begin
                step_idle();
                budget--;
            end
            check("ord_first.timeout", 32'(BranchWorkEn), 1);
        end
        check_data("ord_first", OP_BEQ, 32'h11, 0, 32'h1, 32'h800, 0);
        step_idle();
        check("ord_second.BranchWorkEn", 32'(BranchWorkEn), 1);
        check_data("ord_second", OP_BNE, 32'h22, 0, 32'h2, 32'h804, 1);
        step_idle();
        check("ord_done.BranchWorkEn", 32'(BranchWorkEn), 0);
        check("ord_done.rsFull", 32'(rsFull), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
